prog_loader: RTL



---
 rtl/prog_loader_if.sv | 19 +
 rtl/prog_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if -- byte-stream handshake into the program loader.
//
// Signals
//   byte_in     8-bit stream data
//   byte_valid  byte_in holds a valid byte
//   byte_ready  the loader can accept a byte this cycle
//
// A byte transfers on a rising clock edge where byte_valid && byte_ready.
// The source drives the master modport; the loader uses the slave modport.
// ---------------------------------------------------------------------------
interface prog_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input  byte_ready);
    modport slave  (input  byte_in, input  byte_valid, output byte_ready);
endinterface : prog_loader_if

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader -- write side of the instruction memory.
//
// The loader receives a byte stream of the form
//   LEN_HI LEN_LO  {HI LO} x N  CHECKSUM
// assembles big-endian 16-bit instructions, writes them to consecutive
// instruction-memory addresses starting at 0, and compares the trailing
// byte against the XOR of all instruction bytes. The CPU pipeline is held
// in reset (cpu_hold) until a load completes successfully.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse; begins a load from IDLE, DONE or ERR
//   bus        byte stream (slave side of prog_loader_if)
//   imem_addr  instruction-memory write address
//   imem_data  instruction-memory write data
//   imem_wren  one-cycle write strobe per word
//   cpu_hold   holds the CPU in reset while high (low only in DONE)
//   done       sticky, set when a load succeeds
//   error      sticky, set on an oversize length or a checksum mismatch
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    prog_loader_if.slave      bus,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_data,
    output logic              imem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    // One bit wider than the length field so DEPTH = 65536 still compares.
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t            state;
    logic [7:0]        len_hi_q;   // high byte of the word count
    logic [15:0]       remaining;  // words still to be written
    logic [ADDR_W-1:0] word_idx;   // next instruction-memory address
    logic [7:0]        hi_q;       // high byte of the word being assembled
    logic [7:0]        acc;        // running XOR of instruction bytes

    // byte_ready is a registered copy of "state is a receiving state", so
    // this is exactly the transfer condition seen by the source.
    logic        accept;
    logic [15:0] len_word;

    assign accept   = bus.byte_valid && bus.byte_ready;
    assign len_word = {len_hi_q, bus.byte_in};

    // NOTE: every register here is updated with non-blocking assignments so
    // that all of them sample the pre-edge values of one another; blocking
    // assignments would make later statements see already-updated state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            len_hi_q       <= '0;
            remaining      <= '0;
            word_idx       <= '0;
            hi_q           <= '0;
            acc            <= '0;
            bus.byte_ready <= 1'b0;
            imem_addr      <= '0;
            imem_data      <= '0;
            imem_wren      <= 1'b0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; only DATA_LO raises it.
            imem_wren <= 1'b0;

            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    // start wins over a simultaneous byte: byte_ready is low
                    // in these states, so the byte is never accepted.
                    if (start) begin
                        state          <= S_LEN_HI;
                        done           <= 1'b0;
                        error          <= 1'b0;
                        word_idx       <= '0;
                        acc            <= '0;
                        bus.byte_ready <= 1'b1;
                        cpu_hold       <= 1'b1;
                    end
                end

                S_LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= bus.byte_in;
                        state    <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (accept) begin
                        remaining <= len_word;
                        if ({1'b0, len_word} > DEPTH_W) begin
                            state          <= S_ERR;
                            error          <= 1'b1;
                            bus.byte_ready <= 1'b0;
                        end else if (len_word == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end

                S_DATA_HI: begin
                    if (accept) begin
                        hi_q  <= bus.byte_in;
                        acc   <= acc ^ bus.byte_in;
                        state <= S_DATA_LO;
                    end
                end

                S_DATA_LO: begin
                    if (accept) begin
                        imem_addr <= word_idx;
                        imem_data <= {hi_q, bus.byte_in};
                        imem_wren <= 1'b1;
                        word_idx  <= word_idx + 1'b1;
                        remaining <= remaining - 16'd1;
                        acc       <= acc ^ bus.byte_in;
                        state     <= (remaining == 16'd1) ? S_CHECK : S_DATA_HI;
                    end
                end

                S_CHECK: begin
                    if (accept) begin
                        bus.byte_ready <= 1'b0;
                        if (bus.byte_in == acc) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule : prog_loader
